// File: rtl/wb_common_defs.sv
// Shared Wishbone B4 cycle-type / burst-type encodings and slave state type.
package wb_common_defs;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } wb_state_e;

    // Reserved CTI codes are deliberately treated as classic cycles.
    function automatic logic is_burst_cont(input logic [2:0] cti);
        return (cti == CTI_CONST) || (cti == CTI_INC);
    endfunction

endpackage

// File: rtl/wb_burst_addr_next.sv
// Predicts the next word address of a Wishbone registered-feedback burst beat.
module wb_burst_addr_next
    import wb_common_defs::*;
#(
    parameter int RAW = 8
) (
    input  logic [RAW-1:0] addr_i,
    input  logic [2:0]     cti_i,
    input  logic [1:0]     bte_i,
    output logic [RAW-1:0] addr_next_o
);

    logic [RAW-1:0] addr_inc;
    logic [RAW-1:0] wrap_mask;

    always_comb begin
        addr_inc = addr_i + RAW'(1);
        case (bte_i)
            BTE_WRAP4:  wrap_mask = RAW'(3);
            BTE_WRAP8:  wrap_mask = RAW'(7);
            BTE_WRAP16: wrap_mask = RAW'(15);
            default:    wrap_mask = '1;
        endcase
        // Wrapping bursts only advance the low bits; linear wraps at DEPTH naturally.
        if (cti_i == CTI_INC) begin
            addr_next_o = (addr_i & ~wrap_mask) | (addr_inc & wrap_mask);
        end else begin
            addr_next_o = addr_i;
        end
    end

endmodule

// File: rtl/wb_ram_slave_ctrl.sv
// Wishbone B4 slave front-end for a 1-cycle-latency synchronous RAM.
// ST_IDLE  | no burst in flight; next request takes one setup cycle
// ST_BURST | registered-feedback burst streaming, ack held each beat
module wb_ram_slave_ctrl
    import wb_common_defs::*;
#(
    parameter  int DEPTH = 256,
    localparam int RAW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [31:0]    wb_adr_i,
    input  logic [31:0]    wb_dat_i,
    input  logic [3:0]     wb_sel_i,
    input  logic           wb_we_i,
    input  logic           wb_cyc_i,
    input  logic           wb_stb_i,
    input  logic [2:0]     wb_cti_i,
    input  logic [1:0]     wb_bte_i,
    output logic [31:0]    wb_dat_o,
    output logic           wb_ack_o,
    output logic           wb_err_o,
    output logic [3:0]     ram_we,
    output logic [31:0]    ram_din,
    output logic [RAW-1:0] ram_waddr,
    output logic [RAW-1:0] ram_raddr,
    input  logic [31:0]    ram_dout
);

    logic           req;
    logic           oor;
    logic           burst_cont;
    logic [RAW-1:0] word_addr;
    logic [RAW-1:0] burst_next;
    logic           unused_adr_lsb;

    wb_state_e      state_q, state_d;
    logic           ack_q, ack_d;
    logic           err_q, err_d;

    assign req            = wb_cyc_i & wb_stb_i;
    assign oor            = |wb_adr_i[31:RAW+2];
    assign word_addr      = wb_adr_i[RAW+1:2];
    assign burst_cont     = is_burst_cont(wb_cti_i);
    assign unused_adr_lsb = ^wb_adr_i[1:0];

    wb_burst_addr_next #(.RAW(RAW)) u_addr_next (
        .addr_i      (word_addr),
        .cti_i       (wb_cti_i),
        .bte_i       (wb_bte_i),
        .addr_next_o (burst_next)
    );

    always_comb begin
        ack_d   = req & ~oor & (~ack_q | burst_cont);
        err_d   = req & oor & ~err_q;
        state_d = (ack_q & burst_cont & req & ~oor) ? ST_BURST : ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;
    assign wb_dat_o  = ram_dout;
    assign ram_din   = wb_dat_i;
    assign ram_waddr = word_addr;
    // An out-of-range address aliasing into the RAM must never be written.
    assign ram_we    = wb_sel_i & {4{ack_q & wb_we_i & req & ~oor}};
    // During a streaming burst, fetch the following beat so its data lands on its ack.
    assign ram_raddr = (ack_q & burst_cont) ? burst_next : word_addr;

    a_ack_err_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(ack_q && err_q));
    a_burst_has_ack: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_BURST) |-> ack_q);

endmodule
